// File: rtl/softmax_q88_pkg.sv
// Shared Q8.8 constants for the softmax approximation pipeline stages.
package softmax_q88_pkg;

  localparam int unsigned Q88_W    = 16;
  localparam int unsigned Q88_FRAC = 8;

  localparam logic [15:0] Q88_SMAX = 16'h7FFF;
  localparam logic [15:0] Q88_SMIN = 16'h8000;

  // Integer-part range that the pow2 shifter represents without clamping.
  localparam int POW2_I_MAX = 7;
  localparam int POW2_I_MIN = -8;

  localparam logic [15:0] POW_SAT = 16'hFFFF;

endpackage

// File: rtl/stage2_pow2_approx_pow2_shift.sv
// Combinational 2^d for signed Q8.8 d: linear mantissa 1+F/256 shifted by the
// integer part, clamped to all-ones above the range and flushed to 0 below it.
module pow2_shift
  import softmax_q88_pkg::*;
#(
  parameter int unsigned W    = Q88_W,
  parameter int unsigned FRAC = Q88_FRAC
) (
  input  logic [W-1:0] d,
  output logic [W-1:0] pow,
  output logic         range_sat
);

  logic signed [W-FRAC-1:0] int_part;
  logic        [FRAC-1:0]   frac_part;
  logic        [W-1:0]      mant_ext;
  int                       int_val;

  assign int_part  = d[W-1:FRAC];
  assign frac_part = d[FRAC-1:0];
  assign mant_ext  = {{(W-FRAC-1){1'b0}}, 1'b1, frac_part};

  always_comb begin
    int_val   = int'(int_part);
    pow       = '0;
    range_sat = 1'b0;
    if (int_val > POW2_I_MAX) begin
      pow       = POW_SAT;
      range_sat = 1'b1;
    end else if (int_val >= 0) begin
      pow = mant_ext << int_val;
    end else if (int_val >= POW2_I_MIN) begin
      pow = mant_ext >> (-int_val);
    end else begin
      range_sat = 1'b1;
    end
  end

endmodule

// File: rtl/stage2_pow2_approx.sv
// Softmax stage 2: saturating d = in_1 - log2(in_0), then 2^d, in a 3-deep
// en-stalled pipeline with the denominator carried alongside.
module stage2_pow2_approx
  import softmax_q88_pkg::*;
#(
  parameter int unsigned W    = Q88_W,
  parameter int unsigned FRAC = Q88_FRAC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid_in,
  input  logic [W-1:0] log_in_0,
  input  logic [W-1:0] in_1_bypass,
  input  logic [W-1:0] in_0_bypass,
  output logic         valid_out,
  output logic [W-1:0] pow_out,
  output logic         sat_out,
  output logic [W-1:0] in_0_out
);

  // P1
  logic         v1_q;
  logic [W-1:0] log1_q, in1_1_q, in0_1_q;
  // P2
  logic         v2_q, ovf2_q;
  logic [W-1:0] d2_q, in0_2_q;
  // P3
  logic         v3_q, sat3_q;
  logic [W-1:0] pow3_q, in0_3_q;

  logic [W:0]   diff_d;
  logic         ovf_d;
  logic [W-1:0] d_d;
  logic [W-1:0] pow_d;
  logic         range_sat_d;

  // Sign-extended subtract; overflow shows as the two top bits disagreeing.
  always_comb begin
    diff_d = {in1_1_q[W-1], in1_1_q} - {log1_q[W-1], log1_q};
    ovf_d  = diff_d[W] ^ diff_d[W-1];
    d_d    = diff_d[W-1:0];
    if (ovf_d) d_d = diff_d[W] ? Q88_SMIN : Q88_SMAX;
  end

  pow2_shift #(.W(W), .FRAC(FRAC)) u_pow2_shift (
    .d         (d2_q),
    .pow       (pow_d),
    .range_sat (range_sat_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      log1_q  <= '0;
      in1_1_q <= '0;
      in0_1_q <= '0;
      v2_q    <= 1'b0;
      ovf2_q  <= 1'b0;
      d2_q    <= '0;
      in0_2_q <= '0;
      v3_q    <= 1'b0;
      sat3_q  <= 1'b0;
      pow3_q  <= '0;
      in0_3_q <= '0;
    end else if (en) begin
      v1_q    <= valid_in;
      log1_q  <= log_in_0;
      in1_1_q <= in_1_bypass;
      in0_1_q <= in_0_bypass;
      v2_q    <= v1_q;
      ovf2_q  <= ovf_d;
      d2_q    <= d_d;
      in0_2_q <= in0_1_q;
      v3_q    <= v2_q;
      sat3_q  <= range_sat_d | ovf2_q;
      pow3_q  <= pow_d;
      in0_3_q <= in0_2_q;
    end
  end

  assign valid_out = v3_q;
  assign pow_out   = pow3_q;
  assign sat_out   = sat3_q;
  assign in_0_out  = in0_3_q;

endmodule

// File: tb/tb_stage2_pow2_approx.sv
// Directed bench for stage2_pow2_approx with hand-computed expected values.
module tb_stage2_pow2_approx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid_in;
  logic [15:0] log_in_0;
  logic [15:0] in_1_bypass;
  logic [15:0] in_0_bypass;
  logic        valid_out;
  logic [15:0] pow_out;
  logic        sat_out;
  logic [15:0] in_0_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  stage2_pow2_approx #(.W(16), .FRAC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .valid_in    (valid_in),
    .log_in_0    (log_in_0),
    .in_1_bypass (in_1_bypass),
    .in_0_bypass (in_0_bypass),
    .valid_out   (valid_out),
    .pow_out     (pow_out),
    .sat_out     (sat_out),
    .in_0_out    (in_0_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] in1, input logic [15:0] lg,
                       input logic [15:0] in0);
    valid_in    = v;
    in_1_bypass = in1;
    log_in_0    = lg;
    in_0_bypass = in0;
  endtask

  // One element through an otherwise idle pipe: valid for exactly one cycle.
  task automatic run_one(input string tag, input logic [15:0] in1, input logic [15:0] lg,
                         input logic [15:0] in0, input logic [15:0] exp_pow,
                         input logic exp_sat);
    drive(1'b1, in1, lg, in0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    tick();
    check({tag, " early"}, {15'b0, valid_out}, 16'h0);
    tick();
    check({tag, " valid"}, {15'b0, valid_out}, 16'h1);
    check({tag, " pow"},   pow_out, exp_pow);
    check({tag, " sat"},   {15'b0, sat_out}, {15'b0, exp_sat});
    check({tag, " in0"},   in_0_out, in0);
    tick();
    check({tag, " once"},  {15'b0, valid_out}, 16'h0);
  endtask

  logic [15:0] s_in1 [4] = '{16'h0180, 16'h0000, 16'h0355, 16'h07FF};
  logic [15:0] s_log [4] = '{16'h0080, 16'h0080, 16'h0000, 16'h0000};
  logic [15:0] s_in0 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] s_pow [4] = '{16'h0200, 16'h00C0, 16'h0AA8, 16'hFF80};

  initial begin
    int unsigned in_idx;
    int unsigned out_idx;
    logic        en_now;
    logic        prev_v;
    logic [15:0] prev_pow;

    rst = 1'b0;
    en  = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    #12;
    check("rst valid", {15'b0, valid_out}, 16'h0);
    check("rst pow",   pow_out, 16'h0);
    check("rst sat",   {15'b0, sat_out}, 16'h0);
    check("rst in0",   in_0_out, 16'h0);
    rst = 1'b1;
    tick();

    run_one("d0",      16'h0000, 16'h0000, 16'hA001, 16'h0100, 1'b0);
    run_one("d1",      16'h0180, 16'h0080, 16'hA002, 16'h0200, 1'b0);
    run_one("dm05",    16'h0000, 16'h0080, 16'hA003, 16'h00C0, 1'b0);
    run_one("d0800",   16'h0800, 16'h0000, 16'hA004, 16'hFFFF, 1'b1);
    run_one("dF700",   16'h0000, 16'h0900, 16'hA005, 16'h0000, 1'b1);
    run_one("d07FF",   16'h07FF, 16'h0000, 16'hA006, 16'hFF80, 1'b0);
    run_one("dF800",   16'h0000, 16'h0800, 16'hA007, 16'h0001, 1'b0);
    run_one("d0355",   16'h0355, 16'h0000, 16'hA008, 16'h0AA8, 1'b0);
    run_one("ovf_pos", 16'h7F00, 16'h8000, 16'hA009, 16'hFFFF, 1'b1);
    run_one("ovf_neg", 16'h8000, 16'h0100, 16'hA00A, 16'h0000, 1'b1);

    // Back-to-back stream with a 2-cycle stall after the second element.
    in_idx   = 0;
    out_idx  = 0;
    prev_v   = valid_out;
    prev_pow = pow_out;
    for (int cyc = 0; cyc < 12; cyc++) begin
      en_now = !(cyc == 2 || cyc == 3);
      en     = en_now;
      if (in_idx < 4) drive(1'b1, s_in1[in_idx], s_log[in_idx], s_in0[in_idx]);
      else            drive(1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      if (en_now && in_idx < 4) in_idx++;
      if (!en_now) begin
        check("stall hold valid", {15'b0, valid_out}, {15'b0, prev_v});
        check("stall hold pow",   pow_out, prev_pow);
      end else if (valid_out) begin
        if (out_idx < 4) begin
          check("stream pow", pow_out,  s_pow[out_idx]);
          check("stream in0", in_0_out, s_in0[out_idx]);
          out_idx++;
        end else begin
          check("stream extra", 16'(out_idx), 16'd4);
        end
      end
      prev_v   = valid_out;
      prev_pow = pow_out;
    end
    check("stream count", 16'(out_idx), 16'd4);
    en = 1'b1;

    // Asynchronous reset with three elements in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h7F00, 16'h8000, 16'hB000 + 16'(i));
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    check("pre-rst valid", {15'b0, valid_out}, 16'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async valid", {15'b0, valid_out}, 16'h0);
    check("async pow",   pow_out, 16'h0);
    check("async sat",   {15'b0, sat_out}, 16'h0);
    check("async in0",   in_0_out, 16'h0);
    tick();
    #3;
    rst = 1'b1;
    tick();
    check("post-rst idle", {15'b0, valid_out}, 16'h0);
    run_one("post-rst", 16'h0180, 16'h0080, 16'hC001, 16'h0200, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage2_pow2_approx.md
# stage2_pow2_approx

Second stage of the Q8.8 softmax approximation pipeline. It consumes the stage-1 outputs: the approximate log2 of the denominator and the bypassed element value. It forms the signed difference `d = in_1 − log2(in_0)` and computes `2^d` with a shift-plus-linear-mantissa approximation. The result is a Q8.8 probability term. The block is a 3-deep pipeline with a global stall (`en`) and a valid flag carried alongside the data.

## Interface
Parameters:
- `W`, 16: data width; Q8.8 fixed point.
- `FRAC`, 8: fractional bits.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserting low clears all state immediately, without waiting for a clock edge.
- `en` in 1: pipeline advance. When 0, every register holds, including the valid bits.
- `valid_in` in 1: qualifies the inputs. Driven from stage-1 `valid_out`.
- `log_in_0` in 16: signed Q8.8 approximate log2 of the denominator, from stage 1.
- `in_1_bypass` in 16: signed Q8.8 element value, from stage 1.
- `in_0_bypass` in 16: denominator, carried through unchanged.
- `valid_out` out 1: qualifies the outputs.
- `pow_out` out 16: unsigned Q8.8 approximation of `2^d`.
- `sat_out` out 1: high when the result is clamped to `16'hFFFF` or flushed to 0.
- `in_0_out` out 16: `in_0_bypass`, delayed to stay aligned with `pow_out`.

## Operation
Each pipeline stage updates only when `en = 1`.

- **P1 (input register):** capture `{valid_in, log_in_0, in_1_bypass, in_0_bypass}`.
- **P2 (subtract):**
  - Compute the 17-bit signed difference `in_1 − log_in_0`.
  - Saturate to 16 bits: results above `16'h7FFF` become `16'h7FFF`; results below `16'h8000` become `16'h8000`.
  - Register `d`, a subtract-overflow flag, `valid`, and `in_0`.
- **P3 (pow2):**
  - Split `d` into `I = d[15:8]` (signed integer part) and `F = d[7:0]`.
  - Form the 9-bit Q1.8 mantissa `M = {1'b1, F}`, i.e. `2^F ≈ 1 + F/256`.
  - If `I ≥ 8`: `pow_out = 16'hFFFF`, `sat = 1`.
  - If `0 ≤ I ≤ 7`: `pow_out = M << I`, zero-extended to 16 bits; `sat = 0`.
  - If `−8 ≤ I ≤ −1`: `pow_out = M >> (−I)`, truncated toward zero; `sat = 0`.
  - If `I ≤ −9`: `pow_out = 0`, `sat = 1`.
  - A subtract overflow forces `sat_out = 1` regardless of the branch above.
- No handshake back-pressure exists. Flow control is `en` only; the upstream stage shares the same `en`.

## Timing
- Latency: 3 `en`-qualified cycles from the `valid_in` sample to `valid_out`.
- Throughput: 1 element per enabled cycle.
- `en = 0` freezes all three stages. Outputs hold their last values and `valid_out` does not repeat or drop.
- Bubbles (`valid_in = 0`) propagate as `valid_out = 0`. Data registers still load, so contents during bubbles are don't-care.
- Reset values: `valid_out = 0`, `pow_out = 16'h0000`, `sat_out = 0`, `in_0_out = 16'h0000`, and all internal stages zero.
- Reset asserted mid-stream discards all in-flight elements. The first valid output after reset release appears 3 enabled cycles after the first accepted `valid_in`.
- `en` and `rst` asserted together: reset wins.

## Structure
- Shared package `softmax_q88_pkg` holds:
  - `Q88_W = 16`, `Q88_FRAC = 8`
  - `Q88_SMAX = 16'h7FFF`, `Q88_SMIN = 16'h8000`
  - `POW2_I_MAX = 7`, `POW2_I_MIN = -8`
  - `POW_SAT = 16'hFFFF`
- One combinational sub-module, `pow2_shift`:
  - Input: `d[15:0]`.
  - Outputs: `pow[15:0]`, `range_sat`.
  - Holds the split, mantissa, and bidirectional shift/clamp logic.
  - Instantiated in P3. Unit-testable on its own.
- The top level holds only the P1–P3 registers, the saturating subtractor, and valid/bypass alignment.

## Test plan
- **d = 0:** `in_1 = 16'h0000`, `log_in_0 = 16'h0000` → after 3 cycles, `pow_out = 16'h0100`, `sat_out = 0`, `valid_out = 1` for exactly 1 cycle.
- **Positive and negative d:**
  - `in_1 = 16'h0180`, `log_in_0 = 16'h0080` (d = 1.0) → `pow_out = 16'h0200`.
  - `in_1 = 16'h0000`, `log_in_0 = 16'h0080` (d = −0.5) → `pow_out = 16'h00C0`.
- **Range limits:**
  - d = `16'h0800` → `pow_out = 16'hFFFF`, `sat_out = 1`.
  - d = `16'hF700` (−9) → `pow_out = 0`, `sat_out = 1`.
  - d = `16'h07FF` → `pow_out = 16'hFF80`, `sat_out = 0`.
- **Subtract overflow:** `in_1 = 16'h7F00`, `log_in_0 = 16'h8000` → d clamps to `16'h7FFF` → `pow_out = 16'hFFFF`, `sat_out = 1`.
- **Stall:**
  - Stream 4 back-to-back elements, with `en = 0` for 2 cycles mid-stream → outputs match the reference model in order, with no duplicates or drops.
  - `in_0_out` stays aligned with `pow_out` for every element.
- **Reset:** pull `rst` low asynchronously (between clock edges) with 3 elements in flight → `valid_out` drops to 0 immediately and all outputs read 0. After release, the next element emerges with 3-cycle latency.
